// File: rtl/sam_arbiter.sv
// Round-robin front end that shares one SAM shift-add multiplier among N requesters.
// Latches one request's operands, runs SAM once, returns the product with a watchdog abort.
module sam_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N-1:0]         Req,
  input  logic [N*WIDTH-1:0]   ReqMultiplicand,
  input  logic [N*WIDTH-1:0]   ReqMultiplier,
  output logic [N-1:0]         Grant,
  output logic [N-1:0]         RespValid,
  output logic [2*WIDTH-1:0]   RespProduct,
  output logic                 RespErr,
  output logic                 Busy,
  output logic                 SamStart,
  output logic [WIDTH-1:0]     SamMultiplicand,
  output logic [WIDTH-1:0]     SamMultiplier,
  input  logic [2*WIDTH-1:0]   SamProduct,
  input  logic                 SamDone
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic [N-1:0]       grant_d, resp_valid_d;
  logic [PW-1:0]      prod_d;
  logic               err_d, busy_d, sam_start_d;
  logic [WIDTH-1:0]   mcand_d, mplier_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   scan_pos;
  logic               wdog_hit;

  // Round-robin pick: first asserted Req at or above the pointer, wrapping modulo N.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(ptr_q) + k >= N) begin
        scan_pos = IDX_W'(32'(ptr_q) + k - N);
      end else begin
        scan_pos = IDX_W'(32'(ptr_q) + k);
      end
      if (!pick_valid && Req[scan_pos]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_pos;
      end
    end
  end

  assign wdog_hit = (wdog_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    wdog_d       = wdog_q;
    grant_d      = '0;
    resp_valid_d = '0;
    sam_start_d  = 1'b0;
    busy_d       = Busy;
    prod_d       = RespProduct;
    err_d        = RespErr;
    mcand_d      = SamMultiplicand;
    mplier_d     = SamMultiplier;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          grant_d  = N'(1) << pick_idx;
          busy_d   = 1'b1;
          mcand_d  = ReqMultiplicand[32'(pick_idx) * WIDTH +: WIDTH];
          mplier_d = ReqMultiplier[32'(pick_idx) * WIDTH +: WIDTH];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        sam_start_d = 1'b1;
        wdog_d      = '0;
        state_d     = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A Done left high by the previous operation must fall before we look for the edge.
        wdog_d = wdog_q + CNT_W'(1);
        if (wdog_hit) begin
          prod_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = N'(1) << idx_q;
          state_d      = RESP;
        end else if (!SamDone) begin
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        wdog_d = wdog_q + CNT_W'(1);
        if (SamDone) begin
          prod_d       = SamProduct;
          err_d        = 1'b0;
          resp_valid_d = N'(1) << idx_q;
          state_d      = RESP;
        end else if (wdog_hit) begin
          prod_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = N'(1) << idx_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      idx_q           <= '0;
      wdog_q          <= '0;
      Grant           <= '0;
      RespValid       <= '0;
      RespProduct     <= '0;
      RespErr         <= 1'b0;
      Busy            <= 1'b0;
      SamStart        <= 1'b0;
      SamMultiplicand <= '0;
      SamMultiplier   <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      idx_q           <= idx_d;
      wdog_q          <= wdog_d;
      Grant           <= grant_d;
      RespValid       <= resp_valid_d;
      RespProduct     <= prod_d;
      RespErr         <= err_d;
      Busy            <= busy_d;
      SamStart        <= sam_start_d;
      SamMultiplicand <= mcand_d;
      SamMultiplier   <= mplier_d;
    end
  end

endmodule
